// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, opcode encodings and sweeper state type
package alu_pkg;

  localparam int OP_W       = 4;
  localparam int DATA_W_DEF = 8;

  // Opcode encodings shared by the ALU and anything that drives it.
  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_MUL  = 4'h2;
  localparam logic [OP_W-1:0] OP_DIV  = 4'h3;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h4;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h5;
  localparam logic [OP_W-1:0] OP_ROL  = 4'h6;
  localparam logic [OP_W-1:0] OP_ROR  = 4'h7;
  localparam logic [OP_W-1:0] OP_AND  = 4'h8;
  localparam logic [OP_W-1:0] OP_OR   = 4'h9;
  localparam logic [OP_W-1:0] OP_XOR  = 4'hA;
  localparam logic [OP_W-1:0] OP_NOR  = 4'hB;
  localparam logic [OP_W-1:0] OP_NAND = 4'hC;
  localparam logic [OP_W-1:0] OP_XNOR = 4'hD;
  localparam logic [OP_W-1:0] OP_GT   = 4'hE;
  localparam logic [OP_W-1:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } sweep_state_e;

  // Opcode space is a ring: 15 steps to 0.
  function automatic logic [OP_W-1:0] next_op(input logic [OP_W-1:0] op);
    return op + 4'd1;
  endfunction

endpackage

// File: rtl/alu_op_sweeper.sv
// rtl/alu_op_sweeper.sv - sweeps an inclusive opcode range over one operand pair and streams each ALU result
module alu_op_sweeper
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DATA_W        = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_W-1:0]     cmd_a,
  input  logic [DATA_W-1:0]     cmd_b,
  input  logic [OP_W-1:0]       cmd_op_first,
  input  logic [OP_W-1:0]       cmd_op_last,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [OP_W-1:0]       alu_opcode,
  input  logic [2*DATA_W-1:0]   alu_out,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OP_W-1:0]       res_opcode,
  output logic [2*DATA_W-1:0]   res_data,
  output logic                  res_carry,
  output logic                  res_zero,
  output logic                  res_last,
  output logic                  busy
);

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

  sweep_state_e    state;
  logic [3:0]      cnt;
  logic [OP_W-1:0] last_op;

  // cmd_ready and busy are registered from the next state so no input reaches them combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_op    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      res_valid  <= 1'b0;
      res_opcode <= '0;
      res_data   <= '0;
      res_carry  <= 1'b0;
      res_zero   <= 1'b0;
      res_last   <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_opcode <= cmd_op_first;
            last_op    <= cmd_op_last;
            cnt        <= SETTLE_RELOAD;
            state      <= SETTLE;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
          end
        end

        SETTLE: begin
          if (cnt == 4'd0) begin
            res_data   <= alu_out;
            res_carry  <= alu_carry;
            res_zero   <= alu_zero;
            res_opcode <= alu_opcode;
            res_last   <= (alu_opcode == last_op);
            res_valid  <= 1'b1;
            state      <= EMIT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (res_last) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              alu_opcode <= next_op(alu_opcode);
              cnt        <= SETTLE_RELOAD;
              state      <= SETTLE;
            end
          end
        end

        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sweeper.sv
// tb/tb_alu_op_sweeper.sv - scoreboard bench for alu_op_sweeper with a stub ALU
module tb_alu_op_sweeper;

  localparam int DW = 8;

  typedef struct {
    logic [3:0]      op;
    logic [2*DW-1:0] data;
    logic            carry;
    logic            zero;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // SETTLE_CYCLES=2 instance
  logic            cmd_valid = 1'b0, cmd_ready;
  logic [DW-1:0]   cmd_a = '0, cmd_b = '0;
  logic [3:0]      cmd_op_first = '0, cmd_op_last = '0;
  logic [DW-1:0]   alu_a, alu_b;
  logic [3:0]      alu_opcode;
  logic [2*DW-1:0] alu_out;
  logic            alu_carry, alu_zero;
  logic            res_valid, res_ready = 1'b1;
  logic [3:0]      res_opcode;
  logic [2*DW-1:0] res_data;
  logic            res_carry, res_zero, res_last, busy;

  // SETTLE_CYCLES=1 instance
  logic            cmd_valid1 = 1'b0, cmd_ready1;
  logic [DW-1:0]   alu_a1, alu_b1;
  logic [3:0]      alu_opcode1;
  logic [2*DW-1:0] alu_out1;
  logic            alu_carry1, alu_zero1;
  logic            res_valid1, res_ready1 = 1'b0;
  logic [3:0]      res_opcode1;
  logic [2*DW-1:0] res_data1;
  logic            res_carry1, res_zero1, res_last1, busy1;

  assign alu_out   = {alu_a, alu_b} + 16'(alu_opcode);
  assign alu_carry = alu_opcode[0];
  assign alu_zero  = (alu_opcode == 4'd0);

  assign alu_out1   = {alu_a1, alu_b1} + 16'(alu_opcode1);
  assign alu_carry1 = alu_opcode1[0];
  assign alu_zero1  = (alu_opcode1 == 4'd0);

  alu_op_sweeper #(.SETTLE_CYCLES(2), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op_first(cmd_op_first), .cmd_op_last(cmd_op_last),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_opcode(res_opcode), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .res_last(res_last),
    .busy(busy)
  );

  alu_op_sweeper #(.SETTLE_CYCLES(1), .DATA_W(DW)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(8'h69), .cmd_b(8'h35),
    .cmd_op_first(4'd7), .cmd_op_last(4'd7),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_opcode1),
    .alu_out(alu_out1), .alu_carry(alu_carry1), .alu_zero(alu_zero1),
    .res_valid(res_valid1), .res_ready(res_ready1),
    .res_opcode(res_opcode1), .res_data(res_data1),
    .res_carry(res_carry1), .res_zero(res_zero1), .res_last(res_last1),
    .busy(busy1)
  );

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_res = 0;
  int   accept_cyc = 0;
  int   last_hs_cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Handshake seen at the negedge completes on the following posedge.
  initial forever begin
    @(negedge clk);
    if (!reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("extra_result", 32'(res_opcode), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("res_opcode", 32'(res_opcode), 32'(mon_e.op));
        chk("res_data",   32'(res_data),   32'(mon_e.data));
        chk("res_carry",  32'(res_carry),  32'(mon_e.carry));
        chk("res_zero",   32'(res_zero),   32'(mon_e.zero));
        chk("res_last",   32'(res_last),   32'(mon_e.last));
        n_res++;
        if (mon_e.last) last_hs_cyc = cyc;
      end
    end
  end

  task automatic run_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [3:0] first, input logic [3:0] last);
    logic [3:0] op;
    exp_t e;
    for (int i = 0; i < 200 && !cmd_ready; i++) step();
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    op = first;
    for (int i = 0; i < 16; i++) begin
      e.op    = op;
      e.data  = {a, b} + 16'(op);
      e.carry = op[0];
      e.zero  = (op == 4'd0);
      e.last  = (op == last);
      sb.push_back(e);
      if (op == last) break;
      op = op + 4'd1;
    end
    n_res        = 0;
    cmd_a        = a;
    cmd_b        = b;
    cmd_op_first = first;
    cmd_op_last  = last;
    cmd_valid    = 1'b1;
    accept_cyc   = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) step();
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    step();
    step();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_last", 32'(res_last), 32'd0);
    reset = 1'b0;
    step();

    // Full sweep with ready tied high
    run_cmd(8'h69, 8'h35, 4'd0, 4'd15);
    chk("full_busy_after_accept", 32'(busy), 32'd1);
    chk("full_alu_ab", 32'({alu_a, alu_b}), 32'h6935);
    wait_done("full");
    chk("full_count", 32'(n_res), 32'd16);
    chk("full_cycles", 32'(last_hs_cyc - accept_cyc), 32'd48);

    // Backpressure on op 3
    run_cmd(8'h69, 8'h35, 4'd0, 4'd15);
    for (int i = 0; i < 100 && !(alu_opcode == 4'd3 && !res_valid && busy); i++) step();
    chk("bp_reach_op3", 32'(alu_opcode), 32'd3);
    res_ready = 1'b0;
    for (int i = 0; i < 10 && !res_valid; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_data", 32'(res_data), 32'h6938);
      chk("bp_opcode", 32'(res_opcode), 32'd3);
      chk("bp_alu_opcode", 32'(alu_opcode), 32'd3);
      step();
    end
    res_ready = 1'b1;
    wait_done("bp");
    chk("bp_count", 32'(n_res), 32'd16);

    // Wrapping range
    run_cmd(8'h69, 8'h35, 4'd14, 4'd1);
    wait_done("wrap");
    chk("wrap_count", 32'(n_res), 32'd4);

    // Single op on the SETTLE_CYCLES=1 instance
    cmd_valid1 = 1'b1;
    step();
    cmd_valid1 = 1'b0;
    chk("single_valid_early", 32'(res_valid1), 32'd0);
    chk("single_alu_opcode", 32'(alu_opcode1), 32'd7);
    step();
    chk("single_valid", 32'(res_valid1), 32'd1);
    chk("single_data", 32'(res_data1), 32'h693C);
    chk("single_carry", 32'(res_carry1), 32'd1);
    chk("single_zero", 32'(res_zero1), 32'd0);
    chk("single_last", 32'(res_last1), 32'd1);
    chk("single_opcode", 32'(res_opcode1), 32'd7);
    res_ready1 = 1'b1;
    step();
    res_ready1 = 1'b0;
    chk("single_valid_clear", 32'(res_valid1), 32'd0);
    chk("single_cmd_ready", 32'(cmd_ready1), 32'd1);
    chk("single_busy", 32'(busy1), 32'd0);

    // Command while busy is ignored
    run_cmd(8'h69, 8'h35, 4'd0, 4'd15);
    for (int i = 0; i < 100 && alu_opcode != 4'd4; i++) step();
    cmd_a        = 8'hFF;
    cmd_op_first = 4'd9;
    cmd_op_last  = 4'd9;
    cmd_valid    = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_a     = 8'h69;
    chk("busy_cmd_alu_a", 32'(alu_a), 32'h69);
    wait_done("busy_cmd");
    chk("busy_cmd_count", 32'(n_res), 32'd16);

    // Reset during op 5 settle
    run_cmd(8'h69, 8'h35, 4'd0, 4'd15);
    for (int i = 0; i < 100 && !(alu_opcode == 4'd5 && !res_valid && busy); i++) step();
    chk("rst_mid_reach_op5", 32'(alu_opcode), 32'd5);
    reset = 1'b1;
    step();
    chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_alu_opcode", 32'(alu_opcode), 32'd0);
    reset = 1'b0;
    sb.delete();
    step();
    run_cmd(8'h12, 8'hF0, 4'd2, 4'd4);
    wait_done("after_rst");
    chk("after_rst_count", 32'(n_res), 32'd3);

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
    $finish;
  end

endmodule
